// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Defines the FSM encoding, the prefetch entry layout and the default constants.
// Holds no logic or state.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        FETCH_ST_FETCH   = 1'b0,
        FETCH_ST_DISCARD = 1'b1
    } fetch_st_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_ent_t;

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {pc, inst} entries.
// The head is readable combinationally; push and pop take effect at the next clock edge.
// The caller never pushes while full without also popping; flush overrides push.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  fetch_ent_t               push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_ent_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_ent_t        mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: word reads over req/ack into a prefetch buffer feeding decode.
// Zero-wait memory gives one instruction per cycle; pc/inst come combinationally from the buffer head.
// A decode stall holds the head, and requests stop once the buffer is full.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_b_taken,
    input  logic [31:0] i_b_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_st_e      state;
    fetch_st_e      state_nxt;
    logic [31:0]    fetch_pc;
    logic [31:0]    fetch_pc_nxt;
    logic [31:0]    disc_addr;
    logic [31:0]    disc_addr_nxt;
    logic [CW-1:0]  count;
    fetch_ent_t     head;
    fetch_ent_t     push_dat;
    logic           push;
    logic           pop;
    logic           flush;

    assign valid    = (count != '0);
    assign pop      = valid && !i_stall;
    assign pc       = valid ? head.pc   : 32'h0;
    assign inst     = valid ? head.inst : NOP_INST;
    assign push_dat = '{pc: fetch_pc, inst: i_mem_data};

    always_comb begin
        mem_req       = 1'b0;
        mem_addr      = fetch_pc;
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        disc_addr_nxt = disc_addr;
        push          = 1'b0;
        flush         = 1'b0;

        case (state)
            FETCH_ST_FETCH: begin
                mem_req = (count < CW'(DEPTH)) || pop;
            end
            FETCH_ST_DISCARD: begin
                mem_req  = 1'b1;
                mem_addr = disc_addr;
            end
            default: ;
        endcase

        // A request in flight during reset is abandoned, never completed.
        if (i_rst) begin
            mem_req = 1'b0;
        end

        if (i_b_taken) begin
            flush        = 1'b1;
            fetch_pc_nxt = {i_b_pc[31:2], 2'b00};
            if (state == FETCH_ST_FETCH && mem_req && !i_mem_ack) begin
                state_nxt     = FETCH_ST_DISCARD;
                disc_addr_nxt = fetch_pc;
            end else if (state == FETCH_ST_DISCARD && !i_mem_ack) begin
                state_nxt = FETCH_ST_DISCARD;
            end else begin
                state_nxt = FETCH_ST_FETCH;
            end
        end else if (mem_req && i_mem_ack) begin
            if (state == FETCH_ST_FETCH) begin
                push         = 1'b1;
                fetch_pc_nxt = fetch_pc + 32'd4;
            end else begin
                state_nxt = FETCH_ST_FETCH;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= FETCH_ST_FETCH;
            fetch_pc  <= RESET_PC;
            disc_addr <= RESET_PC;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            disc_addr <= disc_addr_nxt;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buf (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (flush),
        .head     (head),
        .count    (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for zero-wait fetch, stall, redirect and wrap,
// plus hand sequences for slow-memory redirect and reset during an outstanding request.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk;
    logic        i_rst;
    logic        i_stall;
    logic        i_b_taken;
    logic [31:0] i_b_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;

    int errors = 0;
    int checks = 0;
    int mem_lat = 0;
    int wait_cnt = 0;

    typedef struct {
        logic        stall;
        logic        bt;
        logic [31:0] bpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t vecs[$];

    fetch_unit dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_stall    (i_stall),
        .i_b_taken  (i_b_taken),
        .i_b_pc     (i_b_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .i_mem_ack  (i_mem_ack),
        .i_mem_data (i_mem_data),
        .pc         (pc),
        .inst       (inst),
        .valid      (valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory model: acks after mem_lat cycles of request (0 = ack tied high).
    assign i_mem_ack  = (mem_lat == 0) ? 1'b1 : (mem_req && (wait_cnt == mem_lat - 1));
    assign i_mem_data = mem_addr ^ 32'hA5A5_0000;

    always @(posedge i_clk) begin
        if (i_rst || !mem_req || i_mem_ack) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    always @(posedge i_clk) begin
        if (!i_rst) begin
            if (dut.count > 2) begin
                errors++;
                $display("FAIL occupancy: count=%0d limit=2", dut.count);
            end
            if (dut.push && (dut.count == 2) && !dut.pop) begin
                errors++;
                $display("FAIL overflow: push into full buffer without pop");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                             input logic vld, input logic [31:0] epc, input logic [31:0] einst);
        check({tag, "_req"},   {31'b0, mem_req}, {31'b0, req});
        check({tag, "_addr"},  mem_addr,         addr);
        check({tag, "_valid"}, {31'b0, valid},   {31'b0, vld});
        check({tag, "_pc"},    pc,               epc);
        check({tag, "_inst"},  inst,             einst);
    endtask

    task automatic tick(input logic s, input logic b, input logic [31:0] bp);
        @(negedge i_clk);
        i_rst     = 1'b0;
        i_stall   = s;
        i_b_taken = b;
        i_b_pc    = bp;
        #1;
    endtask

    task automatic add(input logic s, input logic b, input logic [31:0] bp, input logic r,
                       input logic [31:0] a, input logic v, input logic [31:0] p, input logic [31:0] i);
        vec_t e;
        e.stall = s; e.bt = b; e.bpc = bp; e.req = r;
        e.addr = a; e.vld = v; e.pc = p; e.inst = i;
        vecs.push_back(e);
    endtask

    initial begin
        //    stall bt  b_pc          req addr          vld pc            inst
        add(0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        NOP);
        add(0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'hA5A5_0000);
        add(0, 0, 32'h0,        1, 32'h8,        1, 32'h4,        32'hA5A5_0004);
        add(0, 0, 32'h0,        1, 32'hC,        1, 32'h8,        32'hA5A5_0008);
        add(1, 0, 32'h0,        1, 32'h10,       1, 32'hC,        32'hA5A5_000C);
        add(1, 0, 32'h0,        0, 32'h14,       1, 32'hC,        32'hA5A5_000C);
        add(1, 0, 32'h0,        0, 32'h14,       1, 32'hC,        32'hA5A5_000C);
        add(0, 0, 32'h0,        1, 32'h14,       1, 32'hC,        32'hA5A5_000C);
        add(0, 0, 32'h0,        1, 32'h18,       1, 32'h10,       32'hA5A5_0010);
        add(1, 0, 32'h0,        0, 32'h1C,       1, 32'h14,       32'hA5A5_0014);
        add(1, 1, 32'h100,      0, 32'h1C,       1, 32'h14,       32'hA5A5_0014);
        add(0, 0, 32'h0,        1, 32'h100,      0, 32'h0,        NOP);
        add(0, 0, 32'h0,        1, 32'h104,      1, 32'h100,      32'hA5A5_0100);
        add(0, 1, 32'hFFFF_FFFE, 1, 32'h108,     1, 32'h104,      32'hA5A5_0104);
        add(0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,       NOP);
        add(0, 0, 32'h0,        1, 32'h0,        1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
        add(0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'hA5A5_0000);
        add(0, 1, 32'h203,      1, 32'h8,        1, 32'h4,        32'hA5A5_0004);
        add(0, 0, 32'h0,        1, 32'h200,      0, 32'h0,        NOP);
        add(0, 0, 32'h0,        1, 32'h204,      1, 32'h200,      32'hA5A5_0200);

        i_rst = 1'b1; i_stall = 1'b0; i_b_taken = 1'b0; i_b_pc = 32'h0;
        repeat (2) @(negedge i_clk);
        #1;
        check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP);

        foreach (vecs[k]) begin
            tick(vecs[k].stall, vecs[k].bt, vecs[k].bpc);
            check_all($sformatf("vec%0d", k), vecs[k].req, vecs[k].addr,
                      vecs[k].vld, vecs[k].pc, vecs[k].inst);
        end

        // Slow memory: redirect while a request waits; the stale data must be dropped.
        @(negedge i_clk);
        i_rst = 1'b1; i_stall = 1'b0; i_b_taken = 1'b0; mem_lat = 3;
        @(negedge i_clk);
        tick(0, 1, 32'h40);
        check("slow_c1_addr", mem_addr, 32'h0);
        tick(0, 0, 32'h0);
        check("slow_c2_addr", mem_addr, 32'h0);
        tick(0, 0, 32'h0);
        check("slow_c3_addr", mem_addr, 32'h0);
        tick(0, 1, 32'h200);
        check("slow_c4_addr", mem_addr, 32'h40);
        check("slow_c4_req", {31'b0, mem_req}, 32'h1);
        for (int c = 5; c <= 6; c++) begin
            tick(0, 0, 32'h0);
            check($sformatf("slow_c%0d_addr", c), mem_addr, 32'h40);
            check($sformatf("slow_c%0d_valid", c), {31'b0, valid}, 32'h0);
        end
        for (int c = 7; c <= 9; c++) begin
            tick(0, 0, 32'h0);
            check($sformatf("slow_c%0d_addr", c), mem_addr, 32'h200);
            check($sformatf("slow_c%0d_valid", c), {31'b0, valid}, 32'h0);
        end

        // Reset while a request is pending and the buffer holds an entry.
        tick(1, 0, 32'h0);
        check_all("slow_c10", 1'b1, 32'h204, 1'b1, 32'h200, 32'hA5A5_0200);
        tick(1, 0, 32'h0);
        check_all("pend_c11", 1'b1, 32'h204, 1'b1, 32'h200, 32'hA5A5_0200);
        @(negedge i_clk);
        i_rst = 1'b1; i_stall = 1'b0;
        #1;
        check("rst_c12_req", {31'b0, mem_req}, 32'h0);
        @(negedge i_clk);
        #1;
        check_all("rst_c13", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        tick(0, 0, 32'h0);
        check_all("rst_c14", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        tick(0, 0, 32'h0);
        tick(0, 0, 32'h0);
        tick(0, 0, 32'h0);
        check_all("rst_c17", 1'b1, 32'h4, 1'b1, 32'h0, 32'hA5A5_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
